// File: rtl/nts_api_axi_bridge_pkg.sv
// rtl/nts_api_axi_bridge_pkg.sv - shared types and constants for the AXI4-Lite to nts_api bridge
package nts_api_axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESP_W = 3'd3,
        ST_RESP_R = 3'd4
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int API_ADDR_WIDTH = 12;

endpackage

// File: rtl/nts_api_axi_bridge.sv
// rtl/nts_api_axi_bridge.sv - AXI4-Lite slave serialising host accesses onto the nts_api port
module nts_api_axi_bridge
    import nts_api_axi_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 14,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      i_clk,
    input  logic                      i_areset,
    input  logic                      i_s_axi_awvalid,
    output logic                      o_s_axi_awready,
    input  logic [ADDR_WIDTH-1:0]     i_s_axi_awaddr,
    input  logic                      i_s_axi_wvalid,
    output logic                      o_s_axi_wready,
    input  logic [31:0]               i_s_axi_wdata,
    input  logic [3:0]                i_s_axi_wstrb,
    output logic                      o_s_axi_bvalid,
    input  logic                      i_s_axi_bready,
    output logic [1:0]                o_s_axi_bresp,
    input  logic                      i_s_axi_arvalid,
    output logic                      o_s_axi_arready,
    input  logic [ADDR_WIDTH-1:0]     i_s_axi_araddr,
    output logic                      o_s_axi_rvalid,
    input  logic                      i_s_axi_rready,
    output logic [31:0]               o_s_axi_rdata,
    output logic [1:0]                o_s_axi_rresp,
    output logic                      o_api_cs,
    output logic                      o_api_we,
    output logic [API_ADDR_WIDTH-1:0] o_api_address,
    output logic [31:0]               o_api_write_data,
    input  logic                      i_api_busy,
    input  logic [31:0]               i_api_read_data,
    input  logic                      i_api_read_data_valid
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    // The last WAIT cycle is the one where the counter shows TIMEOUT_CYCLES-1,
    // so exactly TIMEOUT_CYCLES WAIT cycles elapse before the error response.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(TIMEOUT_CYCLES);

    state_e                    state_q, state_d;
    logic                      last_was_write_q, last_was_write_d;
    logic                      we_q, we_d;
    logic [API_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]               wdata_q, wdata_d;
    logic [31:0]               rdata_q, rdata_d;
    logic [1:0]                resp_q, resp_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

    logic wr_elig, rd_elig, grant_w, grant_r;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{i_s_axi_awaddr[1:0], i_s_axi_araddr[1:0]};

    // Round-robin: on a tie the opposite kind to the last granted access wins.
    assign wr_elig = i_s_axi_awvalid & i_s_axi_wvalid;
    assign rd_elig = i_s_axi_arvalid;
    assign grant_w = ~i_api_busy & wr_elig & (~rd_elig | ~last_was_write_q);
    assign grant_r = ~i_api_busy & rd_elig & (~wr_elig |  last_was_write_q);

    assign o_api_cs         = (state_q == ST_ISSUE);
    assign o_api_we         = we_q;
    assign o_api_address    = addr_q;
    assign o_api_write_data = wdata_q;
    assign o_s_axi_bvalid   = (state_q == ST_RESP_W);
    assign o_s_axi_rvalid   = (state_q == ST_RESP_R);
    assign o_s_axi_bresp    = resp_q;
    assign o_s_axi_rresp    = resp_q;
    assign o_s_axi_rdata    = rdata_q;

    // Request, response and timeout state registers; reset aborts any access in flight.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_q          <= ST_IDLE;
            last_was_write_q <= 1'b0;
            we_q             <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            rdata_q          <= '0;
            resp_q           <= RESP_OKAY;
            cnt_q            <= '0;
        end else begin
            state_q          <= state_d;
            last_was_write_q <= last_was_write_d;
            we_q             <= we_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            rdata_q          <= rdata_d;
            resp_q           <= resp_d;
            cnt_q            <= cnt_d;
        end
    end

    // Next-state logic: accept in IDLE, strobe in ISSUE, wait for completion or timeout, respond.
    always_comb begin
        state_d          = state_q;
        last_was_write_d = last_was_write_q;
        we_d             = we_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        rdata_d          = rdata_q;
        resp_d           = resp_q;
        cnt_d            = cnt_q;
        o_s_axi_awready  = 1'b0;
        o_s_axi_wready   = 1'b0;
        o_s_axi_arready  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_w) begin
                    o_s_axi_awready  = 1'b1;
                    o_s_axi_wready   = 1'b1;
                    last_was_write_d = 1'b1;
                    if (i_s_axi_wstrb == 4'hF) begin
                        we_d    = 1'b1;
                        addr_d  = i_s_axi_awaddr[API_ADDR_WIDTH+1:2];
                        wdata_d = i_s_axi_wdata;
                        state_d = ST_ISSUE;
                    end else begin
                        // Partial writes are not supported by the register map.
                        resp_d  = RESP_SLVERR;
                        state_d = ST_RESP_W;
                    end
                end else if (grant_r) begin
                    o_s_axi_arready  = 1'b1;
                    last_was_write_d = 1'b0;
                    we_d             = 1'b0;
                    addr_d           = i_s_axi_araddr[API_ADDR_WIDTH+1:2];
                    state_d          = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_api_read_data_valid) begin
                    resp_d = RESP_OKAY;
                    if (!we_q) begin
                        rdata_d = i_api_read_data;
                    end
                    state_d = we_q ? ST_RESP_W : ST_RESP_R;
                end else if (cnt_q == CNT_LAST) begin
                    resp_d  = RESP_SLVERR;
                    rdata_d = '0;
                    state_d = we_q ? ST_RESP_W : ST_RESP_R;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP_W: begin
                if (i_s_axi_bready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP_R: begin
                if (i_s_axi_rready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
